// File: rtl/mic_frame_ctrl.sv
// Capture sequencer: pairs L/R mic strobes into a ping-pong sample RAM and hands full banks to the correlator.
// Optional frame counter on frame_seq is enabled with `define MIC_FRAME_SEQ_EN.
module mic_frame_ctrl #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  finished_left,
    input  logic                  finished_right,
    input  logic [DATA_W-1:0]     mic_data_left,
    input  logic [DATA_W-1:0]     mic_data_right,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [2*DATA_W-1:0]   wr_data,
    output logic                  frame_valid,
    output logic                  frame_bank,
    input  logic                  frame_ack,
    output logic                  busy,
    output logic                  overrun,
    output logic [15:0]           frame_seq
);

    localparam int unsigned SEQ_W = 16;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_L = 2'd1,
        WAIT_R = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [DATA_W-1:0]   left_q, left_d;
    logic                wr_en_d;
    logic                wr_bank_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [2*DATA_W-1:0] wr_data_d;
    logic                fv_d;
    logic                fb_d;
    logic                pend_bank, pend_d;
    logic                busy_d;
    logic                overrun_d;
    logic                seq_inc;
    logic                seq_clr;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        left_d    = left_q;
        wr_en_d   = 1'b0;
        wr_bank_d = wr_bank;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        fv_d      = frame_valid;
        fb_d      = frame_bank;
        pend_d    = pend_bank;
        overrun_d = overrun;
        seq_inc   = 1'b0;
        seq_clr   = 1'b0;

        // wr_bank/wr_addr address the pulse in flight; advance once it has gone out
        if (wr_en) begin
            wr_addr_d = wr_addr + ADDR_W'(1);
            if (wr_addr == LAST_ADDR) begin
                wr_bank_d = ~wr_bank;
            end
        end

        // Ack is applied before any bank completion in the same cycle
        if (frame_ack && frame_valid) begin
            fv_d = 1'b0;
        end

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_d   = WAIT_L;
                        wr_bank_d = 1'b0;
                        wr_addr_d = '0;
                        overrun_d = 1'b0;
                        fv_d      = 1'b0;
                        seq_clr   = 1'b1;
                    end
                end
                WAIT_L: begin
                    if (finished_left) begin
                        left_d  = mic_data_left;
                        state_d = WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (finished_right) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {left_q, mic_data_right};
                        state_d   = WAIT_L;
                        if (wr_addr == LAST_ADDR) begin
                            seq_inc = 1'b1;
                            if (fv_d) begin
                                overrun_d = 1'b1;
                                pend_d    = wr_bank;
                                state_d   = HOLD;
                            end else begin
                                fv_d = 1'b1;
                                fb_d = wr_bank;
                            end
                        end
                    end else if (finished_left) begin
                        left_d = mic_data_left;
                    end
                end
                HOLD: begin
                    if (frame_ack && frame_valid) begin
                        fv_d      = 1'b1;
                        fb_d      = pend_bank;
                        wr_addr_d = '0;
                        state_d   = WAIT_L;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            left_q      <= '0;
            wr_en       <= 1'b0;
            wr_bank     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_valid <= 1'b0;
            frame_bank  <= 1'b0;
            pend_bank   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_d;
            left_q      <= left_d;
            wr_en       <= wr_en_d;
            wr_bank     <= wr_bank_d;
            wr_addr     <= wr_addr_d;
            wr_data     <= wr_data_d;
            frame_valid <= fv_d;
            frame_bank  <= fb_d;
            pend_bank   <= pend_d;
            busy        <= busy_d;
            overrun     <= overrun_d;
        end
    end

`ifdef MIC_FRAME_SEQ_EN
    logic [SEQ_W-1:0] seq_q;

    // Completed-frame counter, wraps at 2^16
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q <= '0;
        end else if (seq_clr) begin
            seq_q <= '0;
        end else if (seq_inc) begin
            seq_q <= seq_q + SEQ_W'(1);
        end
    end

    assign frame_seq = seq_q;
`else
    logic unused_seq;
    assign unused_seq = seq_inc ^ seq_clr;
    assign frame_seq  = 16'd0;
`endif

endmodule

// File: tb/tb_mic_frame_ctrl.sv
// Scoreboard bench for mic_frame_ctrl with FRAME_LEN=4; expected RAM writes are queued, a monitor checks them.
module tb_mic_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        start, stop, finished_left, finished_right, frame_ack;
    logic [23:0] mic_data_left, mic_data_right;
    logic        wr_en, wr_bank, frame_valid, frame_bank, busy, overrun;
    logic [1:0]  wr_addr;
    logic [47:0] wr_data;
    logic [15:0] frame_seq;

    typedef struct packed {
        logic        bank;
        logic [1:0]  addr;
        logic [47:0] data;
        logic        chk_fv;
        logic        fb;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mic_frame_ctrl #(.FRAME_LEN(4), .ADDR_W(2), .DATA_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .finished_left(finished_left), .finished_right(finished_right),
        .mic_data_left(mic_data_left), .mic_data_right(mic_data_right),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_valid(frame_valid), .frame_bank(frame_bank), .frame_ack(frame_ack),
        .busy(busy), .overrun(overrun), .frame_seq(frame_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] mk(int l, int r);
        return {24'(l), 24'(r)};
    endfunction

    function automatic logic [15:0] seqx(int n);
`ifdef MIC_FRAME_SEQ_EN
        return 16'(n);
`else
        return 16'd0 + 16'(n - n);
`endif
    endfunction

    task automatic push(logic bank, int addr, logic [47:0] data, logic chk, logic fb);
        exp_t e;
        e.bank = bank; e.addr = 2'(addr); e.data = data; e.chk_fv = chk; e.fb = fb;
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(logic l, logic r, int lv, int rv, logic ack);
        @(negedge clk);
        finished_left = l; finished_right = r; frame_ack = ack;
        mic_data_left = 24'(lv); mic_data_right = 24'(rv);
        @(negedge clk);
        finished_left = 1'b0; finished_right = 1'b0; frame_ack = 1'b0;
    endtask

    task automatic pair(int l, int r);
        pulse(1'b1, 1'b0, l, 0, 1'b0);
        pulse(1'b0, 1'b1, 0, r, 1'b0);
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic do_ack();
        pulse(1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic check_zero(string tag);
        check({tag, ".wr_en"},       64'(wr_en),       64'd0);
        check({tag, ".wr_bank"},     64'(wr_bank),     64'd0);
        check({tag, ".wr_addr"},     64'(wr_addr),     64'd0);
        check({tag, ".wr_data"},     64'(wr_data),     64'd0);
        check({tag, ".frame_valid"}, 64'(frame_valid), 64'd0);
        check({tag, ".frame_bank"},  64'(frame_bank),  64'd0);
        check({tag, ".busy"},        64'(busy),        64'd0);
        check({tag, ".overrun"},     64'(overrun),     64'd0);
        check({tag, ".frame_seq"},   64'(frame_seq),   64'd0);
    endtask

    // Monitor: every write pulse is matched against the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got bank %0d addr %0d data %0h, expected no write",
                             wr_bank, wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_bank", 64'(wr_bank), 64'(e.bank));
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                    if (e.chk_fv) begin
                        check("wr_frame_valid", 64'(frame_valid), 64'd1);
                        check("wr_frame_bank",  64'(frame_bank),  64'(e.fb));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; finished_left = 1'b0; finished_right = 1'b0;
        frame_ack = 1'b0; mic_data_left = '0; mic_data_right = '0;
        repeat (2) @(negedge clk);
        check_zero("por");
        rst = 1'b0;
        idle(1);

        // Basic frame
        do_start();
        check("t1_busy", 64'(busy), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            push(1'b0, i - 1, mk(i, -i), i == 4, 1'b0);
            pair(i, -i);
        end
        check("t1_fv", 64'(frame_valid), 64'd1);
        check("t1_fb", 64'(frame_bank), 64'd0);
        check("t1_seq", 64'(frame_seq), 64'(seqx(1)));
        do_ack();
        check("t1_fv_after_ack", 64'(frame_valid), 64'd0);

        // Alignment, left replace, simultaneous strobes
        do_stop();
        do_start();
        pulse(1'b0, 1'b1, 0, 99, 1'b0);
        push(1'b0, 0, mk(5, 7), 1'b0, 1'b0);
        pair(5, 7);
        push(1'b0, 1, mk(8, 9), 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 8, 100, 1'b0);
        pulse(1'b1, 1'b1, 50, 9, 1'b0);
        pulse(1'b0, 1'b1, 0, 30, 1'b0);
        push(1'b0, 2, mk(21, 22), 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 20, 0, 1'b0);
        pulse(1'b1, 1'b0, 21, 0, 1'b0);
        pulse(1'b0, 1'b1, 0, 22, 1'b0);
        push(1'b0, 3, mk(3, 4), 1'b1, 1'b0);
        pair(3, 4);
        check("t2_fv", 64'(frame_valid), 64'd1);
        do_ack();
        check("t2_fv_after_ack", 64'(frame_valid), 64'd0);

        // Ping-pong and overrun without ack
        do_stop();
        do_start();
        for (int i = 0; i < 8; i++) begin
            push(1'(i / 4), i % 4, mk(10 + i, -(10 + i)), (i % 4) == 3, 1'b0);
            pair(10 + i, -(10 + i));
        end
        idle(1);
        check("t3_overrun", 64'(overrun), 64'd1);
        check("t3_fv", 64'(frame_valid), 64'd1);
        check("t3_fb", 64'(frame_bank), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_seq", 64'(frame_seq), 64'(seqx(2)));
        pair(1, 2);
        pair(3, 4);
        idle(2);
        do_ack();
        check("t3_fv_resume", 64'(frame_valid), 64'd1);
        check("t3_fb_resume", 64'(frame_bank), 64'd1);
        check("t3_overrun_sticky", 64'(overrun), 64'd1);
        push(1'b0, 0, mk(40, 41), 1'b0, 1'b0);
        pair(40, 41);
        idle(1);

        // stop mid-frame, restart, three acked frames
        do_stop();
        idle(1);
        check("t4_busy_stop", 64'(busy), 64'd0);
        check("t4_overrun_held", 64'(overrun), 64'd1);
        check("t4_fv_held", 64'(frame_valid), 64'd1);
        do_start();
        check("t4_overrun_clr", 64'(overrun), 64'd0);
        check("t4_seq_clr", 64'(frame_seq), 64'd0);
        check("t4_fv_clr", 64'(frame_valid), 64'd0);
        push(1'b0, 0, mk(1, 1), 1'b0, 1'b0);
        pair(1, 1);
        push(1'b0, 1, mk(2, 2), 1'b0, 1'b0);
        pair(2, 2);
        do_stop();
        idle(1);
        check("t4_busy_stop2", 64'(busy), 64'd0);
        do_start();
        check("t4_busy_restart", 64'(busy), 64'd1);
        check("t4_overrun_restart", 64'(overrun), 64'd0);
        for (int f = 0; f < 3; f++) begin
            for (int a = 0; a < 4; a++) begin
                push(1'(f % 2), a, mk(f * 16 + a + 1, -(f * 16 + a + 1)), a == 3, 1'(f % 2));
                pair(f * 16 + a + 1, -(f * 16 + a + 1));
            end
            do_ack();
            check("t4_fv_ack", 64'(frame_valid), 64'd0);
        end
        check("t4_seq3", 64'(frame_seq), 64'(seqx(3)));
        check("t4_overrun_none", 64'(overrun), 64'd0);

        // Ack and completion in the same cycle
        do_stop();
        do_start();
        for (int i = 0; i < 7; i++) begin
            push(1'(i / 4), i % 4, mk(50 + i, 60 + i), i == 3, 1'b0);
            pair(50 + i, 60 + i);
        end
        check("t5_fv_before", 64'(frame_valid), 64'd1);
        check("t5_fb_before", 64'(frame_bank), 64'd0);
        push(1'b1, 3, mk(60, 61), 1'b1, 1'b1);
        pulse(1'b1, 1'b0, 60, 0, 1'b0);
        pulse(1'b0, 1'b1, 0, 61, 1'b1);
        idle(1);
        check("t5_overrun", 64'(overrun), 64'd0);
        check("t5_fv", 64'(frame_valid), 64'd1);
        check("t5_fb", 64'(frame_bank), 64'd1);
        check("t5_seq", 64'(frame_seq), 64'(seqx(2)));
        do_ack();
        check("t5_fv_after_ack", 64'(frame_valid), 64'd0);

        // Asynchronous reset mid-frame
        do_stop();
        do_start();
        push(1'b0, 0, mk(70, 71), 1'b0, 1'b0);
        pair(70, 71);
        push(1'b0, 1, mk(72, 73), 1'b0, 1'b0);
        pair(72, 73);
        idle(1);
        check("t6_addr_pre", 64'(wr_addr), 64'd2);
        check("t6_busy_pre", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        do_start();
        check("t6_busy", 64'(busy), 64'd1);
        check("t6_addr", 64'(wr_addr), 64'd0);
        check("t6_bank", 64'(wr_bank), 64'd0);
        push(1'b0, 0, mk(80, 81), 1'b0, 1'b0);
        pair(80, 81);
        idle(2);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
